quant_scheduler: RTL and testbench
==================================

QUANT_SCHEDULER -- requirements
Module: quant_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of OFM requesters sharing the quantizer.
REQ-002 SHALL have parameter IN_W, default 20, accumulator width per requester.
REQ-003 SHALL have parameter OUT_W, default 8, quantized output width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse beginning a layer; sampled only in IDLE.
REQ-007 cfg_shift  input  5  right-shift amount, latched on accepted start.
REQ-008 cfg_count  input  16  number of values to quantize in the layer, latched on accepted start.
REQ-009 req_valid  input  NUM_REQ  per-requester data valid.
REQ-010 req_data  input  NUM_REQ*IN_W  packed unsigned accumulators, requester i at bits [i*IN_W +: IN_W].
REQ-011 req_ready  output  NUM_REQ  one-hot grant/accept; zero when no transfer occurs.
REQ-012 out_valid  output  1  quantized result valid.
REQ-013 out_data  output  OUT_W  quantized result.
REQ-014 out_id  output  clog2(NUM_REQ)  index of the requester that produced out_data.
REQ-015 out_ready  input  1  downstream accept.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the layer completes.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, latching cfg_shift and cfg_count into internal registers.
REQ-019 start with cfg_count=0 SHALL go IDLE->DONE directly, with no grants.
REQ-020 start in any state other than IDLE SHALL be ignored; cfg inputs changing during RUN/DRAIN SHALL have no effect.
REQ-021 In RUN, one transfer per cycle max: transfer to requester i occurs when req_valid[i] and req_ready[i] both high.
REQ-022 Arbitration round-robin: after a transfer to i, priority order starts at (i+1) mod NUM_REQ; after reset priority starts at 0.
REQ-023 req_ready SHALL be all-zero in IDLE, DRAIN, DONE, and whenever the pipeline stalls.
REQ-024 Issued-count register increments per transfer; on the transfer making it equal cfg_count, RUN->DRAIN next cycle.
REQ-025 Pipeline 2 stages: stage 1 registers (req_data >> cfg_shift) and id; stage 2 registers saturated result, id, valid.
REQ-026 Saturation: if shifted value > 2^OUT_W-1, out_data = 2^OUT_W-1, else low OUT_W bits; cfg_shift >= IN_W yields 0.
REQ-027 Latency: transfer in cycle T gives out_valid in cycle T+2 absent stalls; throughput one per cycle.
REQ-028 Stall: out_valid high and out_ready low freezes both stages and blocks new transfers; no data lost or duplicated.
REQ-029 Stage bubbles SHALL be absorbed: stage 1 advances into an empty stage 2 even while stalled output is absent.
REQ-030 DRAIN->DONE when both stages empty and final result accepted; DONE asserts done for one cycle then ->IDLE.
REQ-031 Output order SHALL equal transfer order; out_id SHALL match the granted requester.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, clear counters, pipeline valids, RR pointer to 0; req_ready, out_valid, out_data, out_id, busy, done all 0.
REQ-033 Reset asserted mid-layer SHALL discard in-flight data; no done pulse for the aborted layer.

Verification
REQ-034 start, cfg_shift=4, cfg_count=1, req_valid=0001, data 0x00FF0 -> out_data 0xFF, out_id 0, out_valid at T+2, done pulse after acceptance.
REQ-035 All four req_valid held high, cfg_count=8 -> grants 0,1,2,3,0,1,2,3 each cycle, out_id same sequence, exactly 8 outputs.
REQ-036 cfg_shift=2, data 0xFFFFF -> out_data 0xFF (saturation); cfg_shift=20 -> out_data 0x00.
REQ-037 out_ready low for 5 cycles mid-stream -> out_data/out_id stable, req_ready 0, no loss; resumes one per cycle.
REQ-038 cfg_count=0 start -> done pulse in 1 cycle, req_ready never asserted; start during RUN ignored.
REQ-039 rst_n low during RUN with 2 in flight -> all outputs 0 immediately, busy 0, next start behaves as fresh layer.

Source files
------------

// File: rtl/quant_scheduler.sv
// Round-robin scheduler feeding NUM_REQ accumulator streams through one shared
// shift-and-saturate quantizer, with a layer-level IDLE/RUN/DRAIN/DONE controller.
module quant_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 20,
    parameter int OUT_W   = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4:0]              cfg_shift,
    input  logic [15:0]             cfg_count,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic [ID_W-1:0]         out_id,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q;
    logic [4:0]       shift_q;
    logic [15:0]      count_q;
    logic [15:0]      issued_q;
    logic [ID_W-1:0]  rr_ptr;

    logic             vld_p1;
    logic [IN_W-1:0]  data_p1;
    logic [ID_W-1:0]  id_p1;
    logic             vld_p2;
    logic [OUT_W-1:0] data_p2;
    logic [ID_W-1:0]  id_p2;

    logic             stall;
    logic             xfer;
    logic             last_xfer;
    logic             gnt_hit;
    logic [ID_W-1:0]  gnt_idx;
    logic [IN_W-1:0]  gnt_data;
    logic [IN_W-1:0]  acc [NUM_REQ];

    function automatic logic [IN_W-1:0] shift_acc(input logic [IN_W-1:0] v, input logic [4:0] s);
        if (int'(s) >= IN_W) return '0;
        return v >> s;
    endfunction

    function automatic logic [OUT_W-1:0] saturate(input logic [IN_W-1:0] v);
        if (|v[IN_W-1:OUT_W]) return '1;
        return v[OUT_W-1:0];
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign acc[g] = req_data[g*IN_W +: IN_W];
    end

    // A held output freezes the whole pipe; otherwise both stages always advance.
    assign stall     = vld_p2 & ~out_ready;
    assign xfer      = (state_q == ST_RUN) & ~stall & gnt_hit;
    assign last_xfer = xfer & ((issued_q + 16'd1) == count_q);
    assign gnt_data  = acc[gnt_idx];

    // Round-robin search starting at rr_ptr
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cidx;
        gnt_hit = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        cidx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cidx = ID_W'(cand);
            if (!gnt_hit && req_valid[cidx]) begin
                gnt_hit = 1'b1;
                gnt_idx = cidx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            count_q  <= '0;
            issued_q <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q  <= cfg_shift;
                        count_q  <= cfg_count;
                        issued_q <= '0;
                        state_q  <= (cfg_count == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN:   if (last_xfer) state_q <= ST_DRAIN;
                ST_DRAIN: if (!vld_p1 && (!vld_p2 || out_ready)) state_q <= ST_DONE;
                default:  state_q <= ST_IDLE;
            endcase
            if (xfer) begin
                issued_q <= issued_q + 16'd1;
                rr_ptr   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Stage 1: shift; stage 2: saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            id_p2   <= '0;
        end else if (!stall) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= shift_acc(gnt_data, shift_q);
                id_p1   <= gnt_idx;
            end
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= saturate(data_p1);
                id_p2   <= id_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_id    = id_p2;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_quant_scheduler.sv
// Scoreboard bench for quant_scheduler: transfers push hand-computed results,
// a negedge monitor pops and compares every accepted output.
module tb_quant_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  cfg_shift;
    logic [15:0] cfg_count;
    logic [3:0]  req_valid;
    logic [79:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        busy;
    logic        done;

    quant_scheduler #(.NUM_REQ(4), .IN_W(20), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_shift(cfg_shift),
        .cfg_count(cfg_count), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         id;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         glog[$];
    int         gcyc[$];
    logic [7:0] exp_tab [4];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         out_cnt = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         ready_cnt = 0;
    bit         lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        exp_t       e;
        logic [3:0] g;
        int         idx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
            end else begin
                g = req_valid & req_ready;
                if (req_ready != 4'b0) begin
                    ready_cnt++;
                    check("ready_is_transfer", {28'b0, g}, {28'b0, req_ready});
                    check("ready_onehot", {31'b0, $onehot(req_ready)}, 32'd1);
                end
                if (g != 4'b0) begin
                    idx = 0;
                    for (int k = 0; k < 4; k++) if (g[k]) idx = k;
                    e.d = exp_tab[idx];
                    e.id = idx;
                    e.cyc = cyc;
                    sb.push_back(e);
                    glog.push_back(idx);
                    gcyc.push_back(cyc);
                    xfer_cnt++;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", {24'b0, out_data}, {24'b0, e.d});
                        check("out_id", {30'b0, out_id}, e.id);
                        if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
                    end
                    out_cnt++;
                end
                if (done) done_cnt++;
            end
        end
    endtask

    task automatic set_data(input logic [19:0] d0, input logic [19:0] d1,
                            input logic [19:0] d2, input logic [19:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic start_layer(input logic [4:0] sh, input logic [15:0] cnt);
        @(posedge clk); #1;
        cfg_shift = sh;
        cfg_count = cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= 300) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_out(input int target, input string name);
        int n = 0;
        while (out_cnt < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_cnt < target) check(name, out_cnt, target);
    endtask

    task automatic wait_xfer(input int target, input string name);
        int n = 0;
        while (xfer_cnt < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (xfer_cnt < target) check(name, xfer_cnt, target);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_chk();
        check("rst_req_ready", {28'b0, req_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data",  {24'b0, out_data}, 32'd0);
        check("rst_out_id",    {30'b0, out_id}, 32'd0);
        check("rst_busy",      {31'b0, busy}, 32'd0);
        check("rst_done",      {31'b0, done}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_tests();
        int b_out, b_x, b_done, b_g, b_rdy, b2;
        rst_n = 1'b0; start = 1'b0; cfg_shift = '0; cfg_count = '0;
        req_valid = '0; req_data = '0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) exp_tab[k] = 8'h00;
        @(posedge clk); #1;
        reset_chk();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single value, shift 4, latency and done pulse
        lat_chk = 1'b1;
        set_data(20'h00FF0, 20'h0, 20'h0, 20'h0);
        exp_tab[0] = 8'hFF;
        req_valid = 4'b0001;
        b_out = out_cnt; b_x = xfer_cnt; b_done = done_cnt; b_g = glog.size();
        start_layer(5'd4, 16'd1);
        check("t1_busy", {31'b0, busy}, 32'd1);
        wait_done("t1_done_timeout");
        check("t1_accepted_before_done", out_cnt - b_out, 32'd1);
        @(negedge clk);
        check("t1_done_width", {31'b0, done}, 32'd0);
        settle();
        check("t1_outputs", out_cnt - b_out, 32'd1);
        check("t1_transfers", xfer_cnt - b_x, 32'd1);
        check("t1_done_pulses", done_cnt - b_done, 32'd1);
        check("t1_idle_busy", {31'b0, busy}, 32'd0);
        if (glog.size() > b_g) check("t1_grant", glog[b_g], 32'd0);

        // all requesters valid, round-robin over 8 transfers
        do_reset();
        set_data(20'h00010, 20'h00011, 20'h00012, 20'h00013);
        exp_tab[0] = 8'h10; exp_tab[1] = 8'h11; exp_tab[2] = 8'h12; exp_tab[3] = 8'h13;
        req_valid = 4'b1111;
        b_out = out_cnt; b_x = xfer_cnt; b_done = done_cnt; b_g = glog.size();
        start_layer(5'd0, 16'd8);
        wait_done("t2_done_timeout");
        settle();
        check("t2_outputs", out_cnt - b_out, 32'd8);
        check("t2_transfers", xfer_cnt - b_x, 32'd8);
        check("t2_done_pulses", done_cnt - b_done, 32'd1);
        if (glog.size() >= b_g + 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t2_grant_order", glog[b_g + k], k % 4);
                check("t2_grant_cycle", gcyc[b_g + k] - gcyc[b_g], k);
            end
        end

        // saturation and full shift-out
        req_valid = 4'b0001;
        set_data(20'hFFFFF, 20'h0, 20'h0, 20'h0);
        exp_tab[0] = 8'hFF;
        b_out = out_cnt;
        start_layer(5'd2, 16'd1);
        wait_done("t3a_done_timeout");
        settle();
        check("t3a_outputs", out_cnt - b_out, 32'd1);
        exp_tab[0] = 8'h00;
        b_out = out_cnt;
        start_layer(5'd20, 16'd1);
        wait_done("t3b_done_timeout");
        settle();
        check("t3b_outputs", out_cnt - b_out, 32'd1);

        // five-cycle output stall mid-stream
        do_reset();
        lat_chk = 1'b0;
        set_data(20'h00020, 20'h00021, 20'h00022, 20'h00023);
        exp_tab[0] = 8'h20; exp_tab[1] = 8'h21; exp_tab[2] = 8'h22; exp_tab[3] = 8'h23;
        req_valid = 4'b1111;
        b_out = out_cnt; b_x = xfer_cnt; b_done = done_cnt;
        start_layer(5'd0, 16'd12);
        wait_out(b_out + 3, "t4_pre_stall_timeout");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall_valid", {31'b0, out_valid}, 32'd1);
            check("t4_stall_data", {24'b0, out_data}, 32'h23);
            check("t4_stall_id", {30'b0, out_id}, 32'd3);
            check("t4_stall_ready", {28'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        b2 = out_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("t4_resume_rate", out_cnt - b2, 32'd4);
        wait_done("t4_done_timeout");
        settle();
        check("t4_outputs", out_cnt - b_out, 32'd12);
        check("t4_transfers", xfer_cnt - b_x, 32'd12);
        check("t4_done_pulses", done_cnt - b_done, 32'd1);

        // zero-length layer, then start ignored while running
        b_rdy = ready_cnt; b_done = done_cnt;
        @(posedge clk); #1;
        cfg_shift = 5'd0; cfg_count = 16'd0; start = 1'b1;
        @(negedge clk);
        check("t5_done_before", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t5_done_pulse", {31'b0, done}, 32'd1);
        check("t5_busy_in_done", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("t5_done_width", {31'b0, done}, 32'd0);
        check("t5_idle_busy", {31'b0, busy}, 32'd0);
        check("t5_no_ready", ready_cnt - b_rdy, 32'd0);
        check("t5_done_count", done_cnt - b_done, 32'd1);
        set_data(20'h00030, 20'h00031, 20'h00032, 20'h00033);
        exp_tab[0] = 8'h30; exp_tab[1] = 8'h31; exp_tab[2] = 8'h32; exp_tab[3] = 8'h33;
        b_out = out_cnt; b_done = done_cnt;
        start_layer(5'd0, 16'd4);
        cfg_shift = 5'd8; cfg_count = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5_run_done_timeout");
        settle();
        check("t5_run_outputs", out_cnt - b_out, 32'd4);
        check("t5_run_done_count", done_cnt - b_done, 32'd1);

        // reset with two values in flight, then a fresh layer
        set_data(20'h00040, 20'h00041, 20'h00042, 20'h00043);
        exp_tab[0] = 8'h40; exp_tab[1] = 8'h41; exp_tab[2] = 8'h42; exp_tab[3] = 8'h43;
        b_x = xfer_cnt; b_done = done_cnt;
        start_layer(5'd0, 16'd8);
        wait_xfer(b_x + 2, "t6_xfer_timeout");
        rst_n = 1'b0;
        #1;
        reset_chk();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_done_after_abort", done_cnt - b_done, 32'd0);
        check("t6_idle_after_abort", {31'b0, busy}, 32'd0);
        set_data(20'h00050, 20'h00051, 20'h00052, 20'h00053);
        exp_tab[0] = 8'h50; exp_tab[1] = 8'h51; exp_tab[2] = 8'h52; exp_tab[3] = 8'h53;
        b_out = out_cnt; b_g = glog.size(); b_done = done_cnt;
        start_layer(5'd0, 16'd4);
        wait_done("t6_done_timeout");
        settle();
        check("t6_outputs", out_cnt - b_out, 32'd4);
        check("t6_done_count", done_cnt - b_done, 32'd1);
        check("t6_grant_count", glog.size() - b_g, 32'd4);
        if (glog.size() >= b_g + 4) begin
            for (int k = 0; k < 4; k++) check("t6_grant_order", glog[b_g + k], k);
        end
        check("t6_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        fork
            monitor_loop();
            begin
                run_tests();
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join
    end

endmodule
